vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_vram_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port VRAM arbiter between a line-fetch burst engine and a draw port
module vram_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int RD_LAT     = 2,
    parameter int STARVE_MAX = 64
) (
    input  logic              clk_draw,
    input  logic              rst_draw,

    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic [7:0]        fetch_len,
    output logic              fetch_ack,
    output logic [DATA_W-1:0] fetch_rdata,
    output logic              fetch_rvalid,
    output logic              fetch_done,

    input  logic              draw_req,
    input  logic              draw_we,
    input  logic [ADDR_W-1:0] draw_addr,
    input  logic [DATA_W-1:0] draw_wdata,
    output logic              draw_ack,
    output logic [DATA_W-1:0] draw_rdata,
    output logic              draw_rvalid,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAW  = 2'd2;

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    logic [1:0]        state;
    logic [1:0]        state_nxt;

    // Burst bookkeeping: address of the next beat and beats still owed
    // (including the next one). first_q marks the cycle where the
    // requester's operands are still live on the fetch_* inputs.
    logic [ADDR_W-1:0] f_addr_q;
    logic [8:0]        f_left_q;
    logic              first_q;

    logic [7:0]        starve_cnt;

    logic [8:0]        len_words;
    logic [8:0]        cur_left;
    logic [ADDR_W-1:0] cur_addr;
    logic              beat_last;

    logic              fetch_go;
    logic              draw_go;

    logic              in_fetch;
    logic              in_draw;
    logic              issue_rd;

    // Read-return tags: one entry per issued cycle, oldest at RD_LAT-1.
    logic [RD_LAT-1:0] tag_vld;
    logic [RD_LAT-1:0] tag_own;
    logic [RD_LAT-1:0] tag_last;
    logic              ret_vld;

    // Current beat address/count: on the first beat take them straight from the requester
    always_comb begin
        len_words = (fetch_len == 8'd0) ? 9'd256 : {1'b0, fetch_len};
        cur_left  = first_q ? len_words : f_left_q;
        cur_addr  = first_q ? fetch_addr : f_addr_q;
        beat_last = (cur_left == 9'd1);
    end

    // Arbitration: fetch wins ties until the draw side has waited STARVE_MAX cycles
    always_comb begin
        fetch_go  = fetch_req && (!draw_req || (starve_cnt < STARVE_LIM));
        draw_go   = draw_req && !fetch_go;
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (fetch_go) begin
                    state_nxt = S_FETCH;
                end else if (draw_go) begin
                    state_nxt = S_DRAW;
                end
            end
            S_FETCH: begin
                if (beat_last) begin
                    state_nxt = S_IDLE;
                end
            end
            S_DRAW: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk_draw) begin
        if (rst_draw) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Burst address/count tracking; first_q is raised on the IDLE->FETCH transition only
    always_ff @(posedge clk_draw) begin
        if (rst_draw) begin
            f_addr_q <= '0;
            f_left_q <= '0;
            first_q  <= 1'b0;
        end else begin
            first_q <= (state == S_IDLE) && fetch_go;
            if (state == S_FETCH) begin
                f_addr_q <= cur_addr + ADDR_W'(1);
                f_left_q <= cur_left - 9'd1;
            end
        end
    end

    // Draw wait counter: counts cycles a draw request sits unserved, saturating at 255
    always_ff @(posedge clk_draw) begin
        if (rst_draw) begin
            starve_cnt <= 8'd0;
        end else if (draw_req && !draw_ack) begin
            if (starve_cnt != 8'hFF) begin
                starve_cnt <= starve_cnt + 8'd1;
            end
        end else begin
            starve_cnt <= 8'd0;
        end
    end

    // VRAM bus and handshake outputs; everything is forced low while reset is held
    always_comb begin
        in_fetch  = !rst_draw && (state == S_FETCH);
        in_draw   = !rst_draw && (state == S_DRAW);
        busy      = !rst_draw && (state != S_IDLE);
        fetch_ack = in_fetch && first_q;
        draw_ack  = in_draw;
        mem_en    = in_fetch || in_draw;
        mem_we    = in_draw && draw_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (in_fetch) begin
            mem_addr = cur_addr;
        end else if (in_draw) begin
            mem_addr = draw_addr;
            if (draw_we) begin
                mem_wdata = draw_wdata;
            end
        end
        issue_rd = mem_en && !mem_we;
    end

    // Tag pipeline: tracks owner and burst-last for each outstanding read, independent of the FSM
    always_ff @(posedge clk_draw) begin
        if (rst_draw) begin
            tag_vld  <= '0;
            tag_own  <= '0;
            tag_last <= '0;
        end else begin
            tag_vld[0]  <= issue_rd;
            tag_own[0]  <= in_draw;
            tag_last[0] <= in_fetch && beat_last;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_vld[i]  <= tag_vld[i-1];
                tag_own[i]  <= tag_own[i-1];
                tag_last[i] <= tag_last[i-1];
            end
        end
    end

    // Read-return routing: steer mem_rdata to whichever requester issued the read
    always_comb begin
        ret_vld      = !rst_draw && tag_vld[RD_LAT-1];
        fetch_rvalid = ret_vld && !tag_own[RD_LAT-1];
        draw_rvalid  = ret_vld && tag_own[RD_LAT-1];
        fetch_done   = fetch_rvalid && tag_last[RD_LAT-1];
        fetch_rdata  = fetch_rvalid ? mem_rdata : '0;
        draw_rdata   = draw_rvalid ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - self-checking bench for vram_arbiter
module tb_vram_arbiter;

    localparam int RD_LAT = 2;
    localparam int STARVE_MAX = 64;
    localparam int RN = 3600;
    localparam int RSTOP = 3000;

    logic        clk_draw;
    logic        rst_draw;
    logic        fetch_req;
    logic [15:0] fetch_addr;
    logic [7:0]  fetch_len;
    logic        fetch_ack;
    logic [15:0] fetch_rdata;
    logic        fetch_rvalid;
    logic        fetch_done;
    logic        draw_req;
    logic        draw_we;
    logic [15:0] draw_addr;
    logic [15:0] draw_wdata;
    logic        draw_ack;
    logic [15:0] draw_rdata;
    logic        draw_rvalid;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        busy;

    int total;
    int bad;
    int cyc;

    vram_arbiter #(
        .ADDR_W(16), .DATA_W(16), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk_draw(clk_draw), .rst_draw(rst_draw),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_len(fetch_len),
        .fetch_ack(fetch_ack), .fetch_rdata(fetch_rdata), .fetch_rvalid(fetch_rvalid),
        .fetch_done(fetch_done),
        .draw_req(draw_req), .draw_we(draw_we), .draw_addr(draw_addr),
        .draw_wdata(draw_wdata), .draw_ack(draw_ack), .draw_rdata(draw_rdata),
        .draw_rvalid(draw_rvalid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    initial clk_draw = 1'b0;
    always #5 clk_draw = ~clk_draw;

    always @(posedge clk_draw) cyc <= cyc + 1;

    // Background contents of VRAM; the stored arrays hold only the XOR delta from it.
    function automatic logic [15:0] pat(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    // VRAM model: fixed-latency read pipe, writes land at the clock edge.
    bit [15:0] vdelta [0:65535];
    bit [15:0] rd_pipe [0:3];
    always @(posedge clk_draw) begin
        if (mem_en && mem_we) vdelta[mem_addr] <= mem_wdata ^ pat(mem_addr);
        rd_pipe[0] <= (mem_en && !mem_we) ? (vdelta[mem_addr] ^ pat(mem_addr)) : 16'h0000;
        for (int i = 1; i < 4; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[RD_LAT-1];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h cyc=%0d", nm, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  len;
        int          beats;
        logic [15:0] last;
    } fvec_t;

    fvec_t tbl [4];

    task automatic run_fetch(input fvec_t v);
        int t0, acks, beats, rvs, dones, busyc, ack_off, rv_off, done_off;
        logic [15:0] last_a, ea;
        bit acked;
        acks = 0; beats = 0; rvs = 0; dones = 0; busyc = 0;
        ack_off = -1; rv_off = -1; done_off = -1; last_a = 16'h0; acked = 0;
        @(posedge clk_draw); #1;
        fetch_addr = v.addr; fetch_len = v.len; fetch_req = 1'b1; t0 = cyc;
        for (int i = 0; i < 300; i++) begin
            if (i > 0) begin
                @(posedge clk_draw); #1;
                if (acked) fetch_req = 1'b0;
            end
            @(negedge clk_draw);
            if (fetch_ack) begin acks++; ack_off = cyc - t0; acked = 1; end
            if (busy) busyc++;
            if (mem_en) begin
                ea = v.addr + 16'(beats);
                chk("fetch_addr", mem_addr, ea);
                chk("fetch_we", mem_we, 0);
                last_a = mem_addr;
                beats++;
            end
            if (fetch_rvalid) begin
                if (rvs == 0) rv_off = cyc - t0;
                ea = v.addr + 16'(rvs);
                chk("fetch_data", fetch_rdata, pat(ea));
                rvs++;
            end
            if (fetch_done) begin dones++; done_off = cyc - t0; end
        end
        chk("fetch_ack_cnt", acks, 1);
        chk("fetch_ack_off", ack_off, 1);
        chk("fetch_beats", beats, v.beats);
        chk("fetch_last_addr", last_a, v.last);
        chk("fetch_busy_cyc", busyc, v.beats);
        chk("fetch_rv_cnt", rvs, v.beats);
        chk("fetch_rv_off", rv_off, 1 + RD_LAT);
        chk("fetch_done_cnt", dones, 1);
        chk("fetch_done_off", done_off, v.beats + RD_LAT);
    endtask

    task automatic run_draw_rw();
        int t0, nack, a1, a2, nrv, rv_off;
        bit seen;
        nack = 0; a1 = -1; a2 = -1; nrv = 0; rv_off = -1; seen = 0;
        @(posedge clk_draw); #1;
        draw_req = 1'b1; draw_we = 1'b1; draw_addr = 16'h0040; draw_wdata = 16'hBEEF; t0 = cyc;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) begin
                @(posedge clk_draw); #1;
                if (seen) begin
                    seen = 0;
                    if (nack == 1) draw_we = 1'b0;
                    else draw_req = 1'b0;
                end
            end
            @(negedge clk_draw);
            if (draw_ack) begin
                nack++; seen = 1;
                if (nack == 1) begin
                    a1 = cyc - t0;
                    chk("draw_wr_we", mem_we, 1);
                    chk("draw_wr_data", mem_wdata, 16'hBEEF);
                end else begin
                    a2 = cyc - t0;
                    chk("draw_rd_we", mem_we, 0);
                end
                chk("draw_addr", mem_addr, 16'h0040);
            end
            if (draw_rvalid) begin
                nrv++; rv_off = cyc - t0;
                chk("draw_rd_data", draw_rdata, 16'hBEEF);
            end
        end
        chk("draw_ack_cnt", nack, 2);
        chk("draw_ack1_off", a1, 1);
        chk("draw_ack_gap", a2 - a1, 2);
        chk("draw_rv_cnt", nrv, 1);
        chk("draw_rv_off", rv_off, a2 + RD_LAT);
    endtask

    task automatic run_starve();
        int t0, facks, dacks, f1, f2, d1, nrv;
        facks = 0; dacks = 0; f1 = -1; f2 = -1; d1 = -1; nrv = 0;
        @(posedge clk_draw); #1;
        fetch_addr = 16'h3000; fetch_len = 8'd255; fetch_req = 1'b1;
        draw_req = 1'b1; draw_we = 1'b0; draw_addr = 16'h0010; t0 = cyc;
        for (int i = 0; i < 600; i++) begin
            if (i > 0) begin
                @(posedge clk_draw); #1;
                if (dacks > 0) draw_req = 1'b0;
                if (facks >= 2) fetch_req = 1'b0;
            end
            @(negedge clk_draw);
            if (fetch_ack) begin
                facks++;
                if (facks == 1) f1 = cyc - t0;
                if (facks == 2) f2 = cyc - t0;
            end
            if (draw_ack) begin
                dacks++;
                if (dacks == 1) d1 = cyc - t0;
                chk("starve_draw_addr", mem_addr, 16'h0010);
            end
            if (draw_rvalid) begin
                nrv++;
                chk("starve_draw_data", draw_rdata, pat(16'h0010));
            end
        end
        chk("starve_fetch1_off", f1, 1);
        chk("starve_draw_off", d1, 257);
        chk("starve_fetch2_off", f2, 259);
        chk("starve_draw_cnt", dacks, 1);
        chk("starve_rv_cnt", nrv, 1);
    endtask

    task automatic run_reset_mid();
        int t0, off;
        @(posedge clk_draw); #1;
        fetch_addr = 16'h0200; fetch_len = 8'd8; fetch_req = 1'b1; t0 = cyc;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) begin
                @(posedge clk_draw); #1;
                off = cyc - t0;
                if (off >= 2) fetch_req = 1'b0;
                rst_draw = (off == 3);
            end
            @(negedge clk_draw);
            off = cyc - t0;
            if (off == 2) chk("rst_pre_addr", mem_addr, 16'h0201);
            if (off >= 3) begin
                chk("rst_mem_en", mem_en, 0);
                chk("rst_busy", busy, 0);
                chk("rst_frv", fetch_rvalid, 0);
                chk("rst_done", fetch_done, 0);
                chk("rst_fack", fetch_ack, 0);
                chk("rst_addr", mem_addr, 0);
            end
        end
    endtask

    typedef struct {
        bit busy, en, we, fack, dack, last, frv, drv, done;
        bit [15:0] addr, wdata, rdata;
    } slot_t;

    slot_t sch [0:8191];
    bit [15:0] mdelta [0:65535];

    // Randomized traffic; expectations come from a schedule of future bus cycles.
    task automatic run_random();
        bit f_pend, d_pend;
        int starve, n;
        int idx;
        logic [15:0] a;
        f_pend = 0; d_pend = 0; starve = 0;
        for (int i = 0; i < 65536; i++) mdelta[i] = vdelta[i];
        for (int c = 0; c < RN; c++) begin
            @(posedge clk_draw); #1;
            if (f_pend && c > 0 && sch[c-1].fack) f_pend = 0;
            if (!f_pend && c < RSTOP && $urandom_range(0, 3) == 0) begin
                f_pend = 1;
                fetch_addr = 16'($urandom_range(0, 65535));
                fetch_len = ($urandom_range(0, 31) == 0) ? 8'd0 : 8'($urandom_range(1, 8));
            end
            if (d_pend && c > 0 && sch[c-1].dack) d_pend = 0;
            if (!d_pend && c < RSTOP && $urandom_range(0, 2) == 0) begin
                d_pend = 1;
                draw_we = 1'($urandom_range(0, 1));
                draw_addr = 16'($urandom_range(0, 31));
                draw_wdata = 16'($urandom_range(0, 65535));
            end
            fetch_req = f_pend;
            draw_req = d_pend;

            if (!sch[c].busy) begin
                if (f_pend && (!d_pend || starve < STARVE_MAX)) begin
                    n = (fetch_len == 8'd0) ? 256 : int'(fetch_len);
                    for (int k = 0; k < n; k++) begin
                        idx = c + 1 + k;
                        sch[idx].busy = 1; sch[idx].en = 1;
                        sch[idx].addr = fetch_addr + 16'(k);
                        sch[idx].fack = (k == 0);
                        sch[idx].last = (k == n - 1);
                    end
                end else if (d_pend) begin
                    sch[c+1].busy = 1; sch[c+1].en = 1; sch[c+1].dack = 1;
                    sch[c+1].we = draw_we; sch[c+1].addr = draw_addr;
                    sch[c+1].wdata = draw_we ? draw_wdata : 16'h0000;
                end
            end
            if (d_pend && !sch[c].dack) starve = (starve >= 255) ? 255 : starve + 1;
            else starve = 0;
            if (sch[c].en) begin
                a = sch[c].addr;
                if (sch[c].we) begin
                    mdelta[a] = sch[c].wdata ^ pat(a);
                end else begin
                    idx = c + RD_LAT;
                    sch[idx].rdata = mdelta[a] ^ pat(a);
                    sch[idx].frv = !sch[c].dack;
                    sch[idx].drv = sch[c].dack;
                    sch[idx].done = sch[c].last;
                end
            end

            @(negedge clk_draw);
            chk("rnd_busy", busy, sch[c].busy);
            chk("rnd_en", mem_en, sch[c].en);
            chk("rnd_we", mem_we, sch[c].we);
            chk("rnd_fack", fetch_ack, sch[c].fack);
            chk("rnd_dack", draw_ack, sch[c].dack);
            chk("rnd_frv", fetch_rvalid, sch[c].frv);
            chk("rnd_drv", draw_rvalid, sch[c].drv);
            chk("rnd_done", fetch_done, sch[c].done);
            if (sch[c].en) chk("rnd_addr", mem_addr, sch[c].addr);
            if (sch[c].en && sch[c].we) chk("rnd_wdata", mem_wdata, sch[c].wdata);
            if (sch[c].frv) chk("rnd_frdata", fetch_rdata, sch[c].rdata);
            if (sch[c].drv) chk("rnd_drdata", draw_rdata, sch[c].rdata);
        end
        fetch_req = 1'b0;
        draw_req = 1'b0;
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0;
        rst_draw = 1'b1;
        fetch_req = 1'b1; fetch_addr = 16'h1111; fetch_len = 8'd4;
        draw_req = 1'b1; draw_we = 1'b1; draw_addr = 16'h2222; draw_wdata = 16'h3333;

        tbl[0] = '{addr: 16'h0100, len: 8'd4,   beats: 4,   last: 16'h0103};
        tbl[1] = '{addr: 16'hFFFE, len: 8'd4,   beats: 4,   last: 16'h0001};
        tbl[2] = '{addr: 16'h1234, len: 8'd0,   beats: 256, last: 16'h1333};
        tbl[3] = '{addr: 16'h0000, len: 8'd1,   beats: 1,   last: 16'h0000};

        for (int i = 0; i < 3; i++) begin
            @(negedge clk_draw);
            chk("reset_busy", busy, 0);
            chk("reset_mem_en", mem_en, 0);
            chk("reset_mem_we", mem_we, 0);
            chk("reset_mem_addr", mem_addr, 0);
            chk("reset_mem_wdata", mem_wdata, 0);
            chk("reset_fack", fetch_ack, 0);
            chk("reset_dack", draw_ack, 0);
            chk("reset_frv", fetch_rvalid, 0);
            chk("reset_drv", draw_rvalid, 0);
        end
        @(posedge clk_draw); #1;
        rst_draw = 1'b0; fetch_req = 1'b0; draw_req = 1'b0;
        @(negedge clk_draw);
        chk("idle_busy", busy, 0);
        chk("idle_mem_en", mem_en, 0);

        for (int i = 0; i < 4; i++) begin
            run_fetch(tbl[i]);
            repeat (3) @(posedge clk_draw);
        end
        run_draw_rw();
        repeat (3) @(posedge clk_draw);
        run_starve();
        repeat (3) @(posedge clk_draw);
        run_reset_mid();
        repeat (5) @(posedge clk_draw);
        run_random();
        repeat (5) @(posedge clk_draw);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
